fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock synchronous FIFO, next generation of the project FIFO DUT.
//  - Generalised in data width and depth; depth need not be a power of two.
//  - Programmable almost-full/almost-empty margins.
//  - Selectable read mode: registered (standard) or first-word-fall-through.
//  - Exposes occupancy count; same status/handshake set the FIFO monitor and scoreboard already check.
// PARAMETERS
//  DATA_WIDTH  16  data_in/data_out width in bits (>=1)
//  DEPTH       8   number of storage entries (>=2, any integer)
//  AF_MARGIN   1   almostfull when count >= DEPTH-AF_MARGIN and !full (1..DEPTH-1)
//  AE_MARGIN   1   almostempty when 0 < count <= AE_MARGIN (1..DEPTH-1)
//  FWFT        0   0: registered read, 1-cycle latency; 1: head visible on data_out while !empty
// PORTS
//  clk          in   1                 single clock, all state on rising edge
//  rst          in   1                 asynchronous, active-high reset
//  wr_en        in   1                 write request
//  rd_en        in   1                 read request
//  data_in      in   DATA_WIDTH        write data
//  data_out     out  DATA_WIDTH        read data
//  wr_ack       out  1                 registered: previous-cycle write accepted
//  overflow     out  1                 registered: previous-cycle write rejected (full)
//  underflow    out  1                 registered: previous-cycle read rejected (empty)
//  full         out  1                 count == DEPTH (combinational from count)
//  empty        out  1                 count == 0 (combinational from count)
//  almostfull   out  1                 see AF_MARGIN
//  almostempty  out  1                 see AE_MARGIN
//  count        out  $clog2(DEPTH+1)   current occupancy
// BEHAVIOUR
//  Reset (rst=1, async):
//   - wr_ptr=rd_ptr=count=0; data_out=0; wr_ack=overflow=underflow=0.
//   - Hence empty=1, full=0, almostfull=0, almostempty=0.
//   - Memory contents are not cleared.
//   - Reset asserted mid-operation discards all entries immediately.
//  Write accept = wr_en & !full:
//   - mem[wr_ptr] <= data_in; wr_ptr advances; wr_ack=1 next cycle.
//  Write reject = wr_en & full:
//   - No state change; overflow=1 next cycle.
//  Read accept = rd_en & !empty, rd_ptr advances:
//   - FWFT=0: data_out <= mem[rd_ptr] (valid the cycle after accept); otherwise data_out holds.
//   - FWFT=1: data_out = mem[rd_ptr] combinationally while !empty; 0 while empty.
//  Read reject = rd_en & empty:
//   - underflow=1 next cycle; data_out holds.
//  Pulses:
//   - wr_ack, overflow and underflow are single-cycle registered pulses.
//   - Each is 0 in any cycle following no corresponding request.
//  Simultaneous wr_en & rd_en:
//   - Not full and not empty: both accepted; count unchanged.
//   - Full: read accepted, write rejected (overflow=1); count-1.
//   - Empty: write accepted, read rejected (underflow=1); count+1. No bypass.
//  Pointers: wrap explicitly DEPTH-1 -> 0 (no power-of-two assumption).
//  count: +1 on write-only accept, -1 on read-only accept, else unchanged. Never exceeds DEPTH or goes below 0.
//  Status flags: derived from registered count only; no cycle of lag versus count.
// STRUCTURE
//  fifo_shared_pkg additions:
//   - typedefs fifo_data_t, fifo_cnt_t
//   - localparam defaults FIFO_DEPTH_DEF, FIFO_WIDTH_DEF
//   - enum fifo_rd_mode_e {RD_STD, RD_FWFT}
//  Sub-module fifo_ptr_ctrl: pointer/count/accept/flag logic.
//  Storage: plain register array in the top level.
// TESTING
//  (DATA_WIDTH=16, DEPTH=8, AF=AE=1; run with FWFT=0 and FWFT=1)
//  1. Reset -> empty=1, count=0, all pulses 0.
//     Write 0xA001..0xA008 -> wr_ack=1 x8, almostfull at count=7, full at count=8.
//  2. Full, then wr_en with 0xBEEF -> overflow=1 next cycle, count stays 8.
//     Read all -> 0xA001..0xA008 in order, no 0xBEEF.
//  3. Empty, then rd_en -> underflow=1 next cycle, data_out unchanged, count 0.
//     Single write -> almostempty=1, empty=0.
//  4. Simultaneous wr/rd:
//     - At count=4: count stays 4, ack=1, data in order.
//     - At full: overflow=1, count=7.
//     - At empty: underflow=1, count=1.
//  5. Wrap: 20 write/read pairs at count=3 -> pointers cross 7->0; output sequence matches model.
//  6. Assert rst mid-burst at count=5 -> same cycle empty=1, count=0; later reads underflow until new writes.

Source files
------------

// File: rtl/fifo_shared_pkg.sv
// Shared FIFO definitions: default geometry, data/count types and read-mode enum.
package fifo_shared_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_WIDTH_DEF = 16;

  typedef logic [FIFO_WIDTH_DEF-1:0]           fifo_data_t;
  typedef logic [$clog2(FIFO_DEPTH_DEF+1)-1:0] fifo_cnt_t;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } fifo_rd_mode_e;

  // Pointer width for a given depth; a depth of 1 still needs one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, accept and status-flag control for a synchronous FIFO of any depth.
module fifo_ptr_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  parameter int CNT_W     = 4,
  parameter int PTR_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             wr_accept,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almostfull,
  output logic             almostempty,
  output logic             wr_ack,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(AE_MARGIN);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic rd_accept;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Flags come straight from the registered count, so they never lag it.
  assign full        = (count == CNT_MAX);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_LEVEL) && !full;
  assign almostempty = !empty && (count <= AE_LEVEL);

  // A full FIFO rejects writes even when a read is accepted in the same cycle.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Write pointer advances on each accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= ptr_inc(wr_ptr);
    end
  end

  // Read pointer advances on each accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (rd_accept) begin
      rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Single-cycle handshake pulses reporting the previous cycle's requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable margins and standard or FWFT read.
module fifo_sync_param
  import fifo_shared_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         empty,
  output logic                         almostfull,
  output logic                         almostempty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int            CNT_W   = $clog2(DEPTH + 1);
  localparam int            PTR_W   = fifo_ptr_w(DEPTH);
  localparam fifo_rd_mode_e RD_MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_accept;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN),
    .AE_MARGIN (AE_MARGIN),
    .CNT_W     (CNT_W),
    .PTR_W     (PTR_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_accept   (wr_accept),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Storage is never cleared; reset only empties the FIFO logically.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  generate
    if (RD_MODE == RD_FWFT) begin : g_fwft
      // Head entry shown directly; forced to zero while nothing is stored.
      always_comb begin
        data_out = '0;
        if (!empty) begin
          data_out = mem[rd_ptr];
        end
      end
    end else begin : g_std
      logic                  rd_accept;
      logic [DATA_WIDTH-1:0] data_q;

      assign rd_accept = rd_en && !empty;
      assign data_out  = data_q;

      // Registered read: output updates only on an accepted read, else holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q <= '0;
        end else if (rd_accept) begin
          data_q <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule
